reg_writeback: RTL and testbench
================================

# reg_writeback

Write-side arbiter and buffer for the 32×32 general-purpose register file. Merges single-cycle pipeline results (ALU path, fixed priority) with long-latency multiply/divide results (valid/ready handshake, FIFO-buffered) onto the register file's single write port (`reg_write` / `write_reg` / `write_data`). Sits between the execute/MDU units and the register file. Optionally tracks outstanding MDU destinations for decode-stage hazard checks.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: MDU result buffer entries; power of two, ≥2.
- `STARVE_LIMIT`, default 8: cycles a buffered MDU result may wait before `alu_hold` asserts; 1–255.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `alu_valid`  in  1: pipeline result present this cycle; always accepted.
- `alu_reg`  in  5: pipeline destination register.
- `alu_data`  in  32: pipeline result.
- `mdu_valid`  in  1: MDU result offered.
- `mdu_ready`  out  1: buffer can accept; equals `fifo_count != FIFO_DEPTH`.
- `mdu_reg`  in  5: MDU destination register.
- `mdu_data`  in  32: MDU result.
- `alu_hold`  out  1: request for one pipeline bubble so the buffer can drain.
- `reg_write`  out  1: write enable to register file (registered).
- `write_reg`  out  5: write address (registered).
- `write_data`  out  32: write data (registered).
- `issue_valid`  in  1: MDU operation issued this cycle; marks `issue_reg` pending.
- `issue_reg`  in  5: destination of issued MDU op.
- `chk_reg1`, `chk_reg2`  in  5 each: decode-stage source registers.
- `chk_busy1`, `chk_busy2`  out  1 each: source has an outstanding MDU write.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1: current occupancy.

## Operation
- The MDU handshake completes on a rising edge where `mdu_valid && mdu_ready`. The entry `{mdu_reg, mdu_data}` is pushed at the FIFO tail.
- Output-register load, evaluated every edge:
  - If `alu_valid`: load `{alu_reg, alu_data}`, source = ALU.
  - Else if `fifo_count > 0` (pre-edge value): pop the head and load it, source = MDU.
  - Else: `reg_write` ← 0. `write_reg` and `write_data` hold their previous values.
- Destination 0: the entry is accepted or popped normally, but `reg_write` is driven 0 for it.
- Push and pop on the same edge: count is unchanged. `mdu_ready` uses the pre-edge count, so a full FIFO cannot accept even while popping. There is no bypass around the FIFO.
- Starvation counter, 8 bits, reset 0:
  - Increments each edge where the FIFO is non-empty and no pop occurs. Saturates.
  - Clears on every pop and whenever the FIFO is empty.
  - `alu_hold` = (counter ≥ `STARVE_LIMIT`).
- The pipeline must not present `alu_valid` while `alu_hold` is high. If it does, the ALU still wins and no data is lost; the counter keeps saturating.
- Pointers wrap modulo `FIFO_DEPTH`. Data order is strict FIFO.

## Timing
- Reset values:
  - `reg_write`, `write_reg`, `write_data`: 0.
  - `fifo_count`, pointers, counter: 0; `alu_hold` = 0.
  - Pending map: 0.
  - `mdu_ready` = 1 (combinational from count, so also 1 while `rst_n` is low).
- Reset asserted mid-operation discards all buffered entries and pending bits immediately.
- ALU latency: `alu_valid` sampled at edge N → `reg_write` visible after edge N.
- MDU latency, no ALU traffic: handshake at edge N → pop at edge N+1 → `reg_write` visible after edge N+1.
- `chk_busy*` are combinational from the pending map and `chk_reg*`.

## Configuration
- `WB_SCOREBOARD_EN` defined:
  - A 32-bit pending map is maintained.
  - `issue_valid` with `issue_reg != 0` sets the bit at the edge.
  - A pop of an MDU entry clears the bit for that entry's `mdu_reg` at the pop edge.
  - If set and clear hit the same register on the same edge, set wins.
  - `chk_busyX` = `pending[chk_regX]`; register 0 always reads not busy.
- Not defined: no pending storage exists, `issue_*` inputs are ignored, and `chk_busy1` = `chk_busy2` = 0 constantly.

## Test plan
- Reset, then `alu_valid`=1, `alu_reg`=5, `alu_data`=0xDEADBEEF at edge 1 → after edge 1: `reg_write`=1, `write_reg`=5, `write_data`=0xDEADBEEF. Next idle edge → `reg_write`=0.
- MDU push reg 7 / 0x12345678 at edge 1 with ALU idle → `fifo_count`=1 after edge 1. Write of 7/0x12345678 appears after edge 2; count returns to 0.
- Push 4 MDU entries (regs 1–4) with `alu_valid` held high → `mdu_ready`=0 at count 4. Fifth offer is not accepted. After 8 stalled edges, `alu_hold`=1. Drop `alu_valid` → writes retire in order 1, 2, 3, 4.
- ALU writes to reg 0 and an MDU push to reg 0 → no cycle with `reg_write`=1. The FIFO still drains to `fifo_count`=0.
- With `WB_SCOREBOARD_EN`: `issue_reg`=9, then `chk_reg1`=9 → `chk_busy1`=1. MDU result for reg 9 pops → `chk_busy1`=0 after the pop edge. A re-issue of reg 9 on the same pop edge → stays 1.
- Assert `rst_n`=0 with 3 buffered entries → `fifo_count`=0, `reg_write`=0, `mdu_ready`=1 immediately. No stale write after release.

Source files
------------

// File: rtl/reg_writeback_if.sv
// Write-back bus between execute/MDU producers and reg_writeback.
// master = producer side, slave = the write-back arbiter.
interface reg_writeback_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             alu_valid;
  logic [4:0]       alu_reg;
  logic [31:0]      alu_data;
  logic             mdu_valid;
  logic             mdu_ready;
  logic [4:0]       mdu_reg;
  logic [31:0]      mdu_data;
  logic             alu_hold;
  logic             reg_write;
  logic [4:0]       write_reg;
  logic [31:0]      write_data;
  logic             issue_valid;
  logic [4:0]       issue_reg;
  logic [4:0]       chk_reg1;
  logic [4:0]       chk_reg2;
  logic             chk_busy1;
  logic             chk_busy2;
  logic [CNT_W-1:0] fifo_count;

  modport master (
    output alu_valid, alu_reg, alu_data,
    output mdu_valid, mdu_reg, mdu_data,
    output issue_valid, issue_reg, chk_reg1, chk_reg2,
    input  mdu_ready, alu_hold, reg_write, write_reg, write_data,
    input  chk_busy1, chk_busy2, fifo_count
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  mdu_valid, mdu_reg, mdu_data,
    input  issue_valid, issue_reg, chk_reg1, chk_reg2,
    output mdu_ready, alu_hold, reg_write, write_reg, write_data,
    output chk_busy1, chk_busy2, fifo_count
  );
endinterface

// File: rtl/reg_writeback.sv
// Register-file write-port arbiter: ALU results win, MDU results wait in a FIFO.
// Define WB_SCOREBOARD_EN to track outstanding MDU destinations for decode hazards.
module reg_writeback #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic            clk,
  input logic            rst_n,
  reg_writeback_if.slave wb
);
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]       LIMIT = 8'(STARVE_LIMIT);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [REG_W-1:0]  fifo_reg  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [7:0]        starve;
  logic              push, pop;
  logic [REG_W-1:0]  head_reg;
  logic [DATA_W-1:0] head_data;

  logic              reg_write_p1;
  logic [REG_W-1:0]  write_reg_p1;
  logic [DATA_W-1:0] write_data_p1;

  assign wb.mdu_ready = (count != FULL);
  assign push         = wb.mdu_valid && wb.mdu_ready;
  assign pop          = !wb.alu_valid && (count != '0);
  assign head_reg     = fifo_reg[rd_ptr];
  assign head_data    = fifo_data[rd_ptr];

  // Buffer storage: data only, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg[wr_ptr]  <= wb.mdu_reg;
      fifo_data[wr_ptr] <= wb.mdu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      starve <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (count == '0 || pop) starve <= '0;
      else                    starve <= sat_inc(starve);
    end
  end

  assign wb.alu_hold = (starve >= LIMIT);

  // Stage p1: registered write port; register 0 is consumed but never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_p1  <= 1'b0;
      write_reg_p1  <= '0;
      write_data_p1 <= '0;
    end else if (wb.alu_valid) begin
      reg_write_p1  <= (wb.alu_reg != '0);
      write_reg_p1  <= wb.alu_reg;
      write_data_p1 <= wb.alu_data;
    end else if (pop) begin
      reg_write_p1  <= (head_reg != '0);
      write_reg_p1  <= head_reg;
      write_data_p1 <= head_data;
    end else begin
      reg_write_p1  <= 1'b0;
    end
  end

  assign wb.reg_write  = reg_write_p1;
  assign wb.write_reg  = write_reg_p1;
  assign wb.write_data = write_data_p1;
  assign wb.fifo_count = count;

`ifdef WB_SCOREBOARD_EN
  logic [31:0] pending, pending_nxt;

  // A same-edge re-issue must win over the retiring pop
  always_comb begin
    pending_nxt = pending;
    if (pop) pending_nxt[head_reg] = 1'b0;
    if (wb.issue_valid && wb.issue_reg != '0) pending_nxt[wb.issue_reg] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  assign wb.chk_busy1 = (wb.chk_reg1 != '0) && pending[wb.chk_reg1];
  assign wb.chk_busy2 = (wb.chk_reg2 != '0) && pending[wb.chk_reg2];
`else
  logic unused_issue;
  assign unused_issue = ^{wb.issue_valid, wb.issue_reg, wb.chk_reg1, wb.chk_reg2};
  assign wb.chk_busy1 = 1'b0;
  assign wb.chk_busy2 = 1'b0;
`endif
endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: directed scenarios plus randomized traffic.
module tb_reg_writeback;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   ntests = 0;
  int   nfail  = 0;

  reg_writeback_if #(.FIFO_DEPTH(DEPTH)) wb ();
  reg_writeback #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .wb(wb)
  );

  always #5 clk = ~clk;

  // Reference model state
  ent_t mq[$];
  ent_t exp_q[$];
  int   starve = 0;
  bit   pend[32];
  int   m_pre;
  bit   m_pop, m_push;
  ent_t m_h, m_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        exp_q.delete();
        starve = 0;
        foreach (pend[i]) pend[i] = 1'b0;
      end else begin
        m_pre  = mq.size();
        m_pop  = !wb.alu_valid && m_pre > 0;
        m_push = wb.mdu_valid && m_pre != DEPTH;
        if (wb.alu_valid) begin
          m_e.r = wb.alu_reg;
          m_e.d = wb.alu_data;
          if (m_e.r != 0) exp_q.push_back(m_e);
        end else if (m_pop) begin
          m_h = mq.pop_front();
          if (m_h.r != 0) exp_q.push_back(m_h);
          pend[m_h.r] = 1'b0;
        end
        if (m_push) begin
          m_e.r = wb.mdu_reg;
          m_e.d = wb.mdu_data;
          mq.push_back(m_e);
        end
        if (m_pre == 0 || m_pop) starve = 0;
        else if (starve < 255) starve++;
        if (wb.issue_valid && wb.issue_reg != 0) pend[wb.issue_reg] = 1'b1;
      end
    end
  end

  // Monitor: compare DUT against model away from the active edge
  initial begin
    ent_t g;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (wb.reg_write) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write", {27'd0, wb.write_reg, wb.write_data}, 64'd0);
          end else begin
            g = exp_q.pop_front();
            chk("wr_reg", wb.write_reg, g.r);
            chk("wr_data", wb.write_data, g.d);
          end
        end
        chk("fifo_count", wb.fifo_count, mq.size());
        chk("mdu_ready", wb.mdu_ready, mq.size() != DEPTH);
        chk("alu_hold", wb.alu_hold, starve >= LIMIT);
        chk("chk_busy1", wb.chk_busy1, SB && wb.chk_reg1 != 0 && pend[wb.chk_reg1]);
        chk("chk_busy2", wb.chk_busy2, SB && wb.chk_reg2 != 0 && pend[wb.chk_reg2]);
      end
    end
  end

  task automatic idle_inputs();
    wb.alu_valid = 1'b0; wb.alu_reg = '0; wb.alu_data = '0;
    wb.mdu_valid = 1'b0; wb.mdu_reg = '0; wb.mdu_data = '0;
    wb.issue_valid = 1'b0; wb.issue_reg = '0;
    wb.chk_reg1 = '0; wb.chk_reg2 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_reg_write", wb.reg_write, 1'b0);
    chk("rst_write_reg", wb.write_reg, 5'd0);
    chk("rst_write_data", wb.write_data, 32'd0);
    chk("rst_fifo_count", wb.fifo_count, 0);
    chk("rst_mdu_ready", wb.mdu_ready, 1'b1);
    chk("rst_alu_hold", wb.alu_hold, 1'b0);
    rst_n = 1'b1;
    tick();

    // ALU write and release
    wb.alu_valid = 1'b1; wb.alu_reg = 5'd5; wb.alu_data = 32'hDEADBEEF;
    tick();
    chk("alu_we", wb.reg_write, 1'b1);
    chk("alu_reg", wb.write_reg, 5'd5);
    chk("alu_data", wb.write_data, 32'hDEADBEEF);
    idle_inputs();
    tick();
    chk("alu_idle_we", wb.reg_write, 1'b0);

    // MDU single entry latency
    wb.mdu_valid = 1'b1; wb.mdu_reg = 5'd7; wb.mdu_data = 32'h12345678;
    tick();
    chk("mdu_count1", wb.fifo_count, 1);
    chk("mdu_not_yet", wb.reg_write, 1'b0);
    idle_inputs();
    tick();
    chk("mdu_we", wb.reg_write, 1'b1);
    chk("mdu_reg", wb.write_reg, 5'd7);
    chk("mdu_data", wb.write_data, 32'h12345678);
    chk("mdu_count0", wb.fifo_count, 0);

    // Fill with ALU saturating the port, then starve
    for (int i = 1; i <= 5; i++) begin
      wb.alu_valid = 1'b1; wb.alu_reg = 5'(10 + i); wb.alu_data = $urandom;
      wb.mdu_valid = 1'b1; wb.mdu_reg = 5'(i); wb.mdu_data = 32'hA000_0000 + i;
      tick();
    end
    chk("full_ready", wb.mdu_ready, 1'b0);
    chk("full_count", wb.fifo_count, DEPTH);
    for (int i = 0; i < 6; i++) begin
      wb.alu_reg = 5'(20 + i); wb.alu_data = $urandom;
      tick();
    end
    chk("starve_hold", wb.alu_hold, 1'b1);
    idle_inputs();
    repeat (DEPTH) tick();
    chk("drain_count", wb.fifo_count, 0);
    chk("drain_hold", wb.alu_hold, 1'b0);

    // Register 0 is never written
    wb.alu_valid = 1'b1; wb.alu_reg = 5'd0; wb.alu_data = 32'h1;
    tick();
    chk("r0_alu_we", wb.reg_write, 1'b0);
    idle_inputs();
    wb.mdu_valid = 1'b1; wb.mdu_reg = 5'd0; wb.mdu_data = 32'h2;
    tick();
    idle_inputs();
    tick();
    chk("r0_mdu_we", wb.reg_write, 1'b0);
    chk("r0_count", wb.fifo_count, 0);

    // Pending map: issue, retire, and same-edge re-issue
    wb.issue_valid = 1'b1; wb.issue_reg = 5'd9; wb.chk_reg1 = 5'd9;
    tick();
    wb.issue_valid = 1'b0;
    chk("busy_set", wb.chk_busy1, SB);
    wb.alu_valid = 1'b1; wb.alu_reg = 5'd3; wb.alu_data = 32'h33;
    wb.mdu_valid = 1'b1; wb.mdu_reg = 5'd9; wb.mdu_data = 32'h99;
    tick();
    wb.alu_valid = 1'b0; wb.mdu_valid = 1'b0;
    tick();
    chk("busy_clear", wb.chk_busy1, 1'b0);
    wb.issue_valid = 1'b1;
    tick();
    wb.issue_valid = 1'b0;
    wb.alu_valid = 1'b1; wb.mdu_valid = 1'b1; wb.mdu_data = 32'h98;
    tick();
    wb.alu_valid = 1'b0; wb.mdu_valid = 1'b0; wb.issue_valid = 1'b1;
    tick();
    wb.issue_valid = 1'b0;
    chk("busy_reissue", wb.chk_busy1, SB);
    idle_inputs();
    tick();

    // Asynchronous reset with buffered entries
    for (int i = 0; i < 3; i++) begin
      wb.alu_valid = 1'b1; wb.alu_reg = 5'd12; wb.alu_data = $urandom;
      wb.mdu_valid = 1'b1; wb.mdu_reg = 5'(i + 16); wb.mdu_data = $urandom;
      tick();
    end
    chk("pre_rst_count", wb.fifo_count, 3);
    idle_inputs();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_count", wb.fifo_count, 0);
    chk("arst_we", wb.reg_write, 1'b0);
    chk("arst_ready", wb.mdu_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_we", wb.reg_write, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      wb.alu_valid   = wb.alu_hold ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 99) < 45);
      wb.alu_reg     = 5'($urandom);
      wb.alu_data    = $urandom;
      wb.mdu_valid   = ($urandom_range(0, 1) == 1);
      wb.mdu_reg     = 5'($urandom);
      wb.mdu_data    = $urandom;
      wb.issue_valid = ($urandom_range(0, 3) == 0);
      wb.issue_reg   = 5'($urandom);
      wb.chk_reg1    = 5'($urandom);
      wb.chk_reg2    = 5'($urandom);
      tick();
    end
    idle_inputs();
    repeat (DEPTH + 4) tick();
    chk("final_drain", exp_q.size(), 0);
    chk("final_count", wb.fifo_count, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
